// File: rtl/imem_loader.sv
// Boot loader: 16-bit word-count header then big-endian words into instruction memory.
// One write per 4 accepted bytes (im_we the cycle after the 4th byte); in_ready is state-decoded, so upstream simply stalls.
module imem_loader #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  output logic          core_reset,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [16:0] CAP = 17'(2 ** AW);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  n_hi;
  logic [15:0] n_words;
  logic [AW:0] word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] word_acc;

  logic        acc;
  logic [15:0] hdr_word;
  logic        last_word;

  assign in_ready   = (state == HDR_HI) || (state == HDR_LO) || (state == DATA);
  assign busy       = in_ready || (state == DRAIN);
  assign done       = (state == DONE);
  assign err        = (state == ERR);
  // Core stays in reset everywhere except after a successful load.
  assign core_reset = (state != DONE);

  assign acc       = in_valid && in_ready;
  assign hdr_word  = {n_hi, in_data};
  assign last_word = ((17'(word_idx) + 17'd1) == {1'b0, n_words});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) state_nxt = HDR_HI;
      end
      HDR_HI: begin
        if (acc) state_nxt = HDR_LO;
      end
      HDR_LO: begin
        if (acc) begin
          if (hdr_word == 16'd0) begin
            state_nxt = DONE;
          end else if ({1'b0, hdr_word} > CAP) begin
            state_nxt = ERR;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (acc && (byte_idx == 2'd3) && last_word) state_nxt = DRAIN;
      end
      DRAIN: begin
        state_nxt = DONE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_hi     <= 8'd0;
      n_words  <= 16'd0;
      word_idx <= '0;
      byte_idx <= 2'd0;
      word_acc <= 24'd0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= 32'd0;
    end else begin
      im_we <= 1'b0;
      if (acc) begin
        case (state)
          HDR_HI: begin
            n_hi <= in_data;
          end
          HDR_LO: begin
            n_words  <= hdr_word;
            word_idx <= '0;
            byte_idx <= 2'd0;
          end
          DATA: begin
            if (byte_idx == 2'd3) begin
              im_we    <= 1'b1;
              im_addr  <= word_idx[AW-1:0];
              im_wdata <= {word_acc, in_data};
              word_idx <= word_idx + 1'b1;
              byte_idx <= 2'd0;
            end else begin
              // First byte lands in the MSB.
              case (byte_idx)
                2'd0:    word_acc[23:16] <= in_data;
                2'd1:    word_acc[15:8]  <= in_data;
                default: word_acc[7:0]   <= in_data;
              endcase
              byte_idx <= byte_idx + 2'd1;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: checks outputs after each step against hand-computed values.
module tb_imem_loader;
  localparam int AW = 10;

  logic          clk;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [31:0]   im_wdata;
  logic          core_reset;
  logic          busy;
  logic          done;
  logic          err;

  int vectors = 0;
  int miscompares = 0;

  logic [AW-1:0] wq_addr[$];
  logic [31:0]   wq_data[$];

  imem_loader #(.AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .im_we      (im_we),
    .im_addr    (im_addr),
    .im_wdata   (im_wdata),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe, sampled away from the active edge.
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wq_addr.push_back(im_addr);
      wq_data.push_back(im_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    cyc();
  endtask

  task automatic send_gap(input logic [7:0] b);
    for (int k = 0; k < 3; k++) begin
      if ($urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'hEE;
        cyc();
      end
    end
    send(b);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic do_start();
    in_valid = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic clear_q();
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, ".im_we"}, 32'(im_we), 32'd0);
    chk({tag, ".im_addr"}, 32'(im_addr), 32'd0);
    chk({tag, ".im_wdata"}, im_wdata, 32'd0);
    chk({tag, ".core_reset"}, 32'(core_reset), 32'd1);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".err"}, 32'(err), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    cyc();
    cyc();
    chk_reset_vals("por");
    reset = 1'b1;
    cyc();
    chk("idle.in_ready", 32'(in_ready), 32'd0);

    // Two-word load, continuous valid.
    clear_q();
    do_start();
    chk("s1.in_ready", 32'(in_ready), 32'd1);
    chk("s1.busy", 32'(busy), 32'd1);
    send(8'h00);
    send(8'h02);
    send(8'h20);
    send(8'h08);
    send(8'h00);
    chk("s1.no_we_early", 32'(im_we), 32'd0);
    send(8'h05);
    chk("s1.we0", 32'(im_we), 32'd1);
    chk("s1.addr0", 32'(im_addr), 32'd0);
    chk("s1.data0", im_wdata, 32'h20080005);
    send(8'h01);
    chk("s1.we_pulse", 32'(im_we), 32'd0);
    chk("s1.addr_hold", 32'(im_addr), 32'd0);
    chk("s1.data_hold", im_wdata, 32'h20080005);
    send(8'h09);
    send(8'h50);
    send(8'h20);
    chk("s1.we1", 32'(im_we), 32'd1);
    chk("s1.addr1", 32'(im_addr), 32'd1);
    chk("s1.data1", im_wdata, 32'h01095020);
    chk("s1.drain_ready", 32'(in_ready), 32'd0);
    chk("s1.drain_busy", 32'(busy), 32'd1);
    chk("s1.drain_done", 32'(done), 32'd0);
    chk("s1.drain_corerst", 32'(core_reset), 32'd1);
    idle();
    chk("s1.done", 32'(done), 32'd1);
    chk("s1.core_reset", 32'(core_reset), 32'd0);
    chk("s1.busy_end", 32'(busy), 32'd0);
    chk("s1.nwrites", 32'(wq_addr.size()), 32'd2);

    // Same stream with valid gaps; restart from DONE.
    clear_q();
    do_start();
    chk("s2.done_clr", 32'(done), 32'd0);
    chk("s2.core_reset", 32'(core_reset), 32'd1);
    send_gap(8'h00);
    send_gap(8'h02);
    send_gap(8'h20);
    send_gap(8'h08);
    send_gap(8'h00);
    send_gap(8'h05);
    send_gap(8'h01);
    send_gap(8'h09);
    send_gap(8'h50);
    send_gap(8'h20);
    idle();
    idle();
    chk("s2.done", 32'(done), 32'd1);
    chk("s2.nwrites", 32'(wq_addr.size()), 32'd2);
    if (wq_addr.size() == 2) begin
      chk("s2.addr0", 32'(wq_addr[0]), 32'd0);
      chk("s2.data0", wq_data[0], 32'h20080005);
      chk("s2.addr1", 32'(wq_addr[1]), 32'd1);
      chk("s2.data1", wq_data[1], 32'h01095020);
    end

    // Empty program.
    clear_q();
    do_start();
    send(8'h00);
    send(8'h00);
    chk("s3.done", 32'(done), 32'd1);
    chk("s3.core_reset", 32'(core_reset), 32'd0);
    idle();
    chk("s3.nwrites", 32'(wq_addr.size()), 32'd0);

    // Overflow header 0x0401 = 1025 words, then recovery.
    clear_q();
    do_start();
    send(8'h04);
    send(8'h01);
    chk("s4.err", 32'(err), 32'd1);
    chk("s4.in_ready", 32'(in_ready), 32'd0);
    chk("s4.core_reset", 32'(core_reset), 32'd1);
    chk("s4.done", 32'(done), 32'd0);
    send(8'h99);
    chk("s4.err_hold", 32'(err), 32'd1);
    chk("s4.nwrites", 32'(wq_addr.size()), 32'd0);
    do_start();
    chk("s4.err_clr", 32'(err), 32'd0);
    send(8'h00);
    send(8'h01);
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    send(8'hDD);
    chk("s4.we", 32'(im_we), 32'd1);
    chk("s4.addr", 32'(im_addr), 32'd0);
    chk("s4.data", im_wdata, 32'hAABBCCDD);
    idle();
    chk("s4.done", 32'(done), 32'd1);
    chk("s4.err_end", 32'(err), 32'd0);

    // Full capacity: 0x0400 = 1024 words, word i = 0xDEAD0000 | i.
    clear_q();
    do_start();
    send(8'h04);
    send(8'h00);
    chk("cap.not_err", 32'(err), 32'd0);
    for (int i = 0; i < 1024; i++) begin
      logic [15:0] iw;
      iw = 16'(i);
      send(8'hDE);
      send(8'hAD);
      send(iw[15:8]);
      send(iw[7:0]);
    end
    chk("cap.last_addr", 32'(im_addr), 32'd1023);
    chk("cap.last_data", im_wdata, 32'hDEAD03FF);
    idle();
    chk("cap.done", 32'(done), 32'd1);
    chk("cap.nwrites", 32'(wq_addr.size()), 32'd1024);
    if (wq_addr.size() == 1024) begin
      chk("cap.first_data", wq_data[0], 32'hDEAD0000);
      chk("cap.mid_addr", 32'(wq_addr[512]), 32'd512);
      chk("cap.mid_data", wq_data[512], 32'hDEAD0200);
    end

    // Asynchronous reset mid-word, then a clean reload.
    clear_q();
    do_start();
    send(8'h00);
    send(8'h02);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    send(8'h55);
    send(8'h66);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk_reset_vals("arst");
    cyc();
    reset = 1'b1;
    cyc();
    clear_q();
    do_start();
    send(8'h00);
    send(8'h01);
    send(8'h77);
    send(8'h88);
    send(8'h99);
    send(8'hAA);
    chk("arst.addr", 32'(im_addr), 32'd0);
    chk("arst.data", im_wdata, 32'h778899AA);
    idle();
    chk("arst.done", 32'(done), 32'd1);
    chk("arst.nwrites", 32'(wq_addr.size()), 32'd1);

    // start during DATA is ignored.
    clear_q();
    do_start();
    send(8'h00);
    send(8'h02);
    send(8'hA1);
    send(8'hA2);
    start = 1'b1;
    send(8'hA3);
    start = 1'b0;
    chk("s6.busy", 32'(busy), 32'd1);
    send(8'hA4);
    chk("s6.data0", im_wdata, 32'hA1A2A3A4);
    send(8'hB1);
    send(8'hB2);
    send(8'hB3);
    send(8'hB4);
    chk("s6.addr1", 32'(im_addr), 32'd1);
    chk("s6.data1", im_wdata, 32'hB1B2B3B4);
    idle();
    chk("s6.done", 32'(done), 32'd1);
    chk("s6.nwrites", 32'(wq_addr.size()), 32'd2);

    // start in DONE re-arms and overwrites addr 0.
    clear_q();
    do_start();
    chk("s6.re_done", 32'(done), 32'd0);
    chk("s6.re_corerst", 32'(core_reset), 32'd1);
    send(8'h00);
    send(8'h01);
    send(8'h12);
    send(8'h34);
    send(8'h56);
    send(8'h78);
    chk("s6.re_we", 32'(im_we), 32'd1);
    chk("s6.re_addr", 32'(im_addr), 32'd0);
    chk("s6.re_data", im_wdata, 32'h12345678);
    idle();
    chk("s6.re_fin", 32'(done), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
